// File: rtl/arm_instr_encoder_if.sv
// ============================================================================
// arm_instr_encoder_if : descriptor input channel and imem write channel
// Rev 1.0
// ============================================================================
`default_nettype none

interface arm_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [3:0]  in_cond;
  logic [3:0]  in_cmd;
  logic        in_s;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [11:0] in_src2;
  logic [12:0] in_offset;
  logic [31:0] in_target;
  logic        in_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  in_valid, in_kind, in_cond, in_cmd, in_s, in_rd, in_rn,
           in_src2, in_offset, in_target, in_last, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_kind, in_cond, in_cmd, in_s, in_rd, in_rn,
           in_src2, in_offset, in_target, in_last, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/arm_instr_encoder.sv
// ============================================================================
// arm_instr_encoder : packs decoded descriptors into ARM words and writes imem
// Rev 1.0
// ============================================================================
`default_nettype none

module arm_instr_encoder #(
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         base_addr,
  arm_instr_encoder_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [CW-1:0]       word_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCEPT = 3'd1;
  localparam logic [2:0] EMIT   = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_KIND  = 2'b01;
  localparam logic [1:0] E_RANGE = 2'b10;
  localparam logic [1:0] E_ALIGN = 2'b11;

  logic [2:0]  state;
  logic [31:0] pc;
  logic        last;

  logic [31:0] enc_word;
  logic [1:0]  enc_err;
  logic        off_neg;
  logic [11:0] off_mag;
  logic [31:0] br_diff;
  logic        dp_cmd_ok;
  logic        unused_bits;

  assign off_neg     = bus.in_offset[12];
  assign off_mag     = off_neg ? (12'd0 - bus.in_offset[11:0]) : bus.in_offset[11:0];
  assign br_diff     = bus.in_target - (pc + 32'd8);
  assign dp_cmd_ok   = (bus.in_cmd == 4'b0100) || (bus.in_cmd == 4'b0010) ||
                       (bus.in_cmd == 4'b0000) || (bus.in_cmd == 4'b1100) ||
                       (bus.in_cmd == 4'b1101);
  assign unused_bits = &{1'b0, base_addr[1:0], br_diff[1:0]};

  always_comb begin
    enc_word = 32'd0;
    enc_err  = E_NONE;
    case (bus.in_kind)
      3'b000, 3'b001: begin
        if (!dp_cmd_ok) begin
          enc_err = E_KIND;
        end else begin
          // MOV has no first operand; its Rn field is architecturally zero
          enc_word = {bus.in_cond, 2'b00, bus.in_kind[0], bus.in_cmd, bus.in_s,
                      (bus.in_cmd == 4'b1101) ? 4'b0000 : bus.in_rn,
                      bus.in_rd, bus.in_src2};
        end
      end
      3'b010, 3'b011: begin
        // -4096 is the only 13-bit value whose magnitude needs 13 bits
        if (bus.in_offset == 13'h1000) begin
          enc_err = E_RANGE;
        end else begin
          enc_word = {bus.in_cond, 2'b01, 1'b0, 1'b1, ~off_neg, 1'b0, 1'b0,
                      ~bus.in_kind[0], bus.in_rn, bus.in_rd, off_mag};
        end
      end
      3'b100, 3'b101: begin
        if (bus.in_target[1:0] != 2'b00) begin
          enc_err = E_ALIGN;
        end else if (!((br_diff[31:25] == 7'h00) || (br_diff[31:25] == 7'h7f))) begin
          enc_err = E_RANGE;
        end else begin
          enc_word = {bus.in_cond, 3'b101, bus.in_kind[0], br_diff[25:2]};
        end
      end
      default: enc_err = E_KIND;
    endcase
  end

  assign bus.in_ready = (state == ACCEPT);
  assign bus.wr_valid = (state == EMIT);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= 32'd0;
      last        <= 1'b0;
      bus.wr_addr <= 32'd0;
      bus.wr_data <= 32'd0;
      word_count  <= '0;
      err         <= 1'b0;
      err_code    <= E_NONE;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            pc         <= {base_addr[31:2], 2'b00};
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= E_NONE;
            state      <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (bus.in_valid) begin
            if (enc_err != E_NONE) begin
              err      <= 1'b1;
              err_code <= enc_err;
              state    <= ERR;
            end else begin
              bus.wr_data <= enc_word;
              bus.wr_addr <= pc;
              last        <= bus.in_last;
              state       <= EMIT;
            end
          end
        end
        EMIT: begin
          if (bus.wr_ready) begin
            pc         <= pc + 32'd4;
            word_count <= word_count + 1'b1;
            state      <= last ? DONE : ACCEPT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
